// File: rtl/node_array_sequencer.sv
// Initiator side of the FEA node command interface: loads initial node values,
// broadcasts kval/dt, issues the programmed STEP burst and streams final values out.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for start; kval/dt/step_count hold last run's values
// S_LOAD      | accepting init words, one LOAD command per handshake
// S_STEP      | issuing contiguous STEP commands until step_count == num_steps
// S_READ_REQ  | READ command visible; node_val_in captured at end of cycle
// S_READ_WAIT | result word presented on out_valid until out_ready
// S_DONE      | one-cycle done pulse, then back to idle
module node_array_sequencer #(
  parameter int NUM_NODES = 8,
  parameter int SEL_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_steps,
  input  logic [31:0]      kval_in,
  input  logic [31:0]      dt_in,
  input  logic             init_valid,
  output logic             init_ready,
  input  logic [31:0]      init_data,
  output logic [2:0]       command,
  output logic [SEL_W-1:0] node_sel,
  output logic [31:0]      load_data,
  output logic [31:0]      kval,
  output logic [31:0]      dt,
  input  logic [31:0]      node_val_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [15:0]      step_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_READ_REQ,
    S_READ_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] CMD_HOLD = 3'b000;
  localparam logic [2:0] CMD_LOAD = 3'b001;
  localparam logic [2:0] CMD_STEP = 3'b010;
  localparam logic [2:0] CMD_READ = 3'b011;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_NODES - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_idx;
  logic [15:0]      r_num_steps;
  logic [15:0]      r_step_count;
  logic [31:0]      r_kval;
  logic [31:0]      r_dt;
  logic [2:0]       r_cmd;
  logic [SEL_W-1:0] r_sel;
  logic [31:0]      r_load_data;
  logic [31:0]      r_out_data;
  logic             r_out_last;

  state_t           w_state_nxt;
  logic [SEL_W-1:0] w_idx_nxt;
  logic [15:0]      w_num_steps_nxt;
  logic [15:0]      w_step_count_nxt;
  logic [31:0]      w_kval_nxt;
  logic [31:0]      w_dt_nxt;
  logic [2:0]       w_cmd_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [31:0]      w_load_data_nxt;
  logic [31:0]      w_out_data_nxt;
  logic             w_out_last_nxt;
  logic             w_init_hs;
  logic             w_out_hs;

  assign w_init_hs = (r_state == S_LOAD) && init_valid;
  assign w_out_hs  = (r_state == S_READ_WAIT) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_num_steps  <= '0;
      r_step_count <= '0;
      r_kval       <= '0;
      r_dt         <= '0;
      r_cmd        <= CMD_HOLD;
      r_sel        <= '0;
      r_load_data  <= '0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_num_steps  <= w_num_steps_nxt;
      r_step_count <= w_step_count_nxt;
      r_kval       <= w_kval_nxt;
      r_dt         <= w_dt_nxt;
      r_cmd        <= w_cmd_nxt;
      r_sel        <= w_sel_nxt;
      r_load_data  <= w_load_data_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_last   <= w_out_last_nxt;
    end
  end

  // Commands are registered, so the READ for the next node is issued from the
  // state that precedes S_READ_REQ; it is then visible during S_READ_REQ itself.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_num_steps_nxt  = r_num_steps;
    w_step_count_nxt = r_step_count;
    w_kval_nxt       = r_kval;
    w_dt_nxt         = r_dt;
    w_cmd_nxt        = CMD_HOLD;
    w_sel_nxt        = r_sel;
    w_load_data_nxt  = r_load_data;
    w_out_data_nxt   = r_out_data;
    w_out_last_nxt   = r_out_last;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_num_steps_nxt  = num_steps;
          w_kval_nxt       = kval_in;
          w_dt_nxt         = dt_in;
          w_idx_nxt        = '0;
          w_step_count_nxt = '0;
          w_state_nxt      = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_init_hs) begin
          w_cmd_nxt       = CMD_LOAD;
          w_sel_nxt       = r_idx;
          w_load_data_nxt = init_data;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_STEP;
          end else begin
            w_idx_nxt = r_idx + SEL_W'(1);
          end
        end
      end
      S_STEP: begin
        if (r_step_count < r_num_steps) begin
          w_cmd_nxt        = CMD_STEP;
          w_step_count_nxt = r_step_count + 16'd1;
        end else begin
          w_cmd_nxt   = CMD_READ;
          w_sel_nxt   = r_idx;
          w_state_nxt = S_READ_REQ;
        end
      end
      S_READ_REQ: begin
        w_out_data_nxt = node_val_in;
        w_out_last_nxt = (r_idx == LAST_IDX);
        w_state_nxt    = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (w_out_hs) begin
          if (r_out_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + SEL_W'(1);
            w_cmd_nxt   = CMD_READ;
            w_sel_nxt   = r_idx + SEL_W'(1);
            w_state_nxt = S_READ_REQ;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign init_ready = (r_state == S_LOAD);
  assign out_valid  = (r_state == S_READ_WAIT);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign command    = r_cmd;
  assign node_sel   = r_sel;
  assign load_data  = r_load_data;
  assign kval       = r_kval;
  assign dt         = r_dt;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_node_array_sequencer.sv
// Bench for node_array_sequencer: behavioural node array responder plus a
// closed-form model of the expected final node values and run timing.
module tb_node_array_sequencer;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   num_steps = '0;
  logic [31:0]   kval_in = '0;
  logic [31:0]   dt_in = '0;
  logic          init_valid = 1'b0;
  logic          init_ready;
  logic [31:0]   init_data = '0;
  logic [2:0]    command;
  logic [SW-1:0] node_sel;
  logic [31:0]   load_data;
  logic [31:0]   kval;
  logic [31:0]   dt;
  logic [31:0]   node_val_in;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [15:0]   step_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  node_array_sequencer #(.NUM_NODES(N), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
    .kval_in(kval_in), .dt_in(dt_in), .init_valid(init_valid),
    .init_ready(init_ready), .init_data(init_data), .command(command),
    .node_sel(node_sel), .load_data(load_data), .kval(kval), .dt(dt),
    .node_val_in(node_val_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .step_count(step_count)
  );

  // Node array: LOAD writes one node, STEP adds (kval^dt)+i to node i.
  logic [31:0] mem [N];
  bit          fixed_mode = 1'b0;
  assign node_val_in = fixed_mode ? (32'd100 + 32'(node_sel)) : mem[node_sel];

  always @(posedge clk) begin
    if (command == 3'b001) mem[node_sel] <= load_data;
    else if (command == 3'b010)
      for (int i = 0; i < N; i++) mem[i] <= mem[i] + (kval ^ dt) + 32'(i);
  end

  // Observation log, cleared whenever run_id changes.
  int          run_id = 0;
  int          seen_id = 0;
  int          cyc = 0;
  int          start_cyc = -1, done_cyc = -1, last_load = -1;
  int          first_step = -1, last_step = -1, first_read = -1;
  int          n_steps = 0, done_n = 0, illegal = 0, stab_viol = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  int          ld_sel_q[$];
  logic [31:0] ld_data_q[$];
  int          rd_sel_q[$];
  logic [31:0] o_data_q[$];
  logic        o_last_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (seen_id != run_id) begin
      seen_id <= run_id;
      start_cyc <= -1; done_cyc <= -1; last_load <= -1;
      first_step <= -1; last_step <= -1; first_read <= -1;
      n_steps <= 0; done_n <= 0; illegal <= 0; stab_viol <= 0;
      prev_stall <= 1'b0;
      ld_sel_q.delete(); ld_data_q.delete(); rd_sel_q.delete();
      o_data_q.delete(); o_last_q.delete();
    end else begin
      if (start && !busy) start_cyc <= cyc;
      case (command)
        3'b000: ;
        3'b001: begin
          ld_sel_q.push_back(int'(node_sel));
          ld_data_q.push_back(load_data);
          last_load <= cyc;
        end
        3'b010: begin
          n_steps <= n_steps + 1;
          if (first_step < 0) first_step <= cyc;
          last_step <= cyc;
        end
        3'b011: begin
          rd_sel_q.push_back(int'(node_sel));
          if (first_read < 0) first_read <= cyc;
        end
        default: illegal <= illegal + 1;
      endcase
      if (prev_stall && out_valid && (out_data !== prev_data || out_last !== prev_last))
        stab_viol <= stab_viol + 1;
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_last  <= out_last;
      if (out_valid && out_ready) begin
        o_data_q.push_back(out_data);
        o_last_q.push_back(out_last);
      end
      if (done) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_cmd"}, 64'(command), 64'(0));
    chk({tag, "_sel"}, 64'(node_sel), 64'(0));
    chk({tag, "_ldata"}, 64'(load_data), 64'(0));
    chk({tag, "_kval"}, 64'(kval), 64'(0));
    chk({tag, "_dt"}, 64'(dt), 64'(0));
    chk({tag, "_odata"}, 64'(out_data), 64'(0));
    chk({tag, "_stepcnt"}, 64'(step_count), 64'(0));
    chk({tag, "_flags"}, 64'({init_ready, out_valid, out_last, busy, done}), 64'(0));
  endtask

  task automatic run(input int s, input logic [31:0] k, input logic [31:0] d,
                     input bit fixed, input int gap_mode, input int stall_word,
                     input int stall_len, input bit busy_start);
    logic [31:0] vals [N];
    logic [31:0] e;
    int          gaps_total;
    int          len_exp;
    for (int i = 0; i < N; i++) vals[i] = fixed ? 32'(10 * (i + 1)) : $urandom;
    fixed_mode = fixed;
    gaps_total = 0;
    run_id++;
    @(posedge clk); #1;
    start = 1'b1; num_steps = s[15:0]; kval_in = k; dt_in = d; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; num_steps = 16'($urandom); kval_in = $urandom; dt_in = $urandom;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          int g;
          int cnt;
          g = (i == 0) ? 0 : (gap_mode == 1) ? ((i == 1) ? 2 : 0)
                           : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
          repeat (g) begin
            init_valid = 1'b0;
            @(posedge clk); #1;
            gaps_total++;
          end
          init_valid = 1'b1;
          init_data  = vals[i];
          cnt = 0;
          @(negedge clk);
          while (!init_ready && cnt < 200) begin @(negedge clk); cnt++; end
          @(posedge clk); #1;
        end
        init_valid = 1'b0;
      end
      begin
        if (stall_len > 0) begin
          int cnt;
          cnt = 0;
          while (o_data_q.size() < stall_word && cnt < 1000) begin @(posedge clk); #1; cnt++; end
          out_ready = 1'b0;
          cnt = 0;
          while (!out_valid && cnt < 1000) begin @(posedge clk); #1; cnt++; end
          repeat (stall_len) begin @(posedge clk); #1; end
          out_ready = 1'b1;
        end
      end
      begin
        if (busy_start) begin
          int cnt;
          cnt = 0;
          while (command != 3'b010 && cnt < 500) begin @(posedge clk); #1; cnt++; end
          start = 1'b1; num_steps = 16'd9; kval_in = ~k; dt_in = ~d;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      begin
        int cnt;
        cnt = 0;
        while (done_n == 0 && cnt < 3000) begin @(posedge clk); #1; cnt++; end
      end
    join
    repeat (6) @(posedge clk);
    #1;

    chk("n_loads", 64'(ld_sel_q.size()), 64'(N));
    for (int i = 0; i < N; i++) if (i < ld_sel_q.size()) begin
      chk("load_sel", 64'(ld_sel_q[i]), 64'(i));
      chk("load_data", 64'(ld_data_q[i]), 64'(vals[i]));
    end
    chk("n_steps", 64'(n_steps), 64'(s));
    if (s > 0) begin
      chk("step_contig", 64'(last_step - first_step + 1), 64'(s));
      chk("step_after_load", 64'(first_step), 64'(last_load + 1));
      chk("read_after_step", 64'(first_read), 64'(last_step + 1));
    end else begin
      chk("read_after_load", 64'(first_read), 64'(last_load + 1));
    end
    chk("n_reads", 64'(rd_sel_q.size()), 64'(N));
    for (int i = 0; i < N; i++) if (i < rd_sel_q.size())
      chk("read_sel", 64'(rd_sel_q[i]), 64'(i));
    chk("n_out", 64'(o_data_q.size()), 64'(N));
    for (int i = 0; i < N; i++) if (i < o_data_q.size()) begin
      e = fixed ? (32'd100 + 32'(i)) : (vals[i] + 32'(s) * ((k ^ d) + 32'(i)));
      chk("out_data", 64'(o_data_q[i]), 64'(e));
      chk("out_last", 64'(o_last_q[i]), 64'(i == N - 1));
    end
    len_exp = 3 * N + s + 2 + gaps_total + stall_len;
    chk("done_count", 64'(done_n), 64'(1));
    chk("run_length", 64'(done_cyc - start_cyc), 64'(len_exp));
    chk("step_count", 64'(step_count), 64'(s));
    chk("kval_hold", 64'(kval), 64'(k));
    chk("dt_hold", 64'(dt), 64'(d));
    chk("busy_after", 64'(busy), 64'(0));
    chk("stall_stable", 64'(stab_viol), 64'(0));
    chk("illegal_cmd", 64'(illegal), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("busy_post_reset", 64'(busy), 64'(0));

    // directed runs
    run(3, $urandom, $urandom, 1'b1, 0, 0, 0, 1'b0);
    run(0, $urandom, $urandom, 1'b0, 0, 0, 0, 1'b0);
    run(2, $urandom, $urandom, 1'b0, 1, 0, 0, 1'b0);
    run(4, $urandom, $urandom, 1'b0, 0, 2, 5, 1'b0);
    run(6, $urandom, $urandom, 1'b0, 0, 0, 0, 1'b1);

    // reset in the middle of the LOAD phase
    run_id++;
    @(posedge clk); #1;
    start = 1'b1; num_steps = 16'd5; kval_in = 32'h1234_5678; dt_in = 32'h9abc_def0;
    @(posedge clk); #1;
    start = 1'b0; init_valid = 1'b1; init_data = 32'h7;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle_zero("midreset");
    init_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_busy", 64'(busy), 64'(0));
    chk("midreset_done", 64'(done_n), 64'(0));
    chk("midreset_nout", 64'(o_data_q.size()), 64'(0));

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      int s;
      s = int'($urandom_range(0, 12));
      run(s, $urandom, $urandom, 1'b0, int'($urandom_range(0, 2)),
          int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4)),
          (s > 0) && ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
